gpio_in_debounce: RTL and testbench

Input-side companion to the board's GPIO output logic. It synchronises, debounces and edge-detects the external GPIO header pins, which are otherwise held high-Z. It gives the fabric clean levels, single-cycle rise/fall pulses, and sticky per-pin event flags with an aggregate interrupt. It sits between the top-level GPIO inout pins, read-only, and any fabric consumer such as a control FSM or a status register bank.

---
 rtl/gpio_in_debounce.sv | 90 +++++++++
 tb/tb_gpio_in_debounce.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// Synchronise, debounce and edge-detect the GPIO header inputs. Each pin becomes
// a clean level, one-cycle rise/fall pulses and a sticky event flag; any set flag raises irq_o.
module gpio_in_debounce #(
  parameter int WIDTH      = 24,
  parameter int TICK_DIV   = 16000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] event_clr,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] event_o,
  output logic             irq_o
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  CNT_LAST  = 4'(STABLE_CNT - 1);

  logic [WIDTH-1:0]      sync1_q, sync1_d;
  logic [WIDTH-1:0]      sync2_q, sync2_d;
  logic [15:0]           presc_q, presc_d;
  logic                  tick;
  logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      level_q, level_d;
  logic [WIDTH-1:0]      rise_q, rise_d;
  logic [WIDTH-1:0]      fall_q, fall_d;
  logic [WIDTH-1:0]      event_q, event_d;

  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    // A pin must disagree with its accepted level on STABLE_CNT consecutive
    // ticks; any agreeing tick throws away the partial count.
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = 4'd0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = 4'd0;
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
    // Setting has priority over clearing so an edge landing on a clear is kept.
    event_d = (event_q & ~event_clr) | rise_q | fall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;
  assign irq_o   = |event_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce: expected pulses are queued when pins are
// driven and matched by a monitor when rise_o/fall_o fire, including latency windows.
module tb_gpio_in_debounce;

  localparam int W = 24;

  typedef struct {
    string       tag;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int          min_cyc;
    int          max_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpio_in;
  logic [W-1:0] event_clr;
  logic [W-1:0] level_o, rise_o, fall_o, event_o;
  logic         irq_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  gpio_in_debounce #(.WIDTH(W), .TICK_DIV(4), .STABLE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .event_clr(event_clr),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .event_o(event_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [W-1:0] r,
                            input logic [W-1:0] f, input int lo, input int hi);
    exp_t e;
    e.tag = tag; e.rise = r; e.fall = f;
    e.min_cyc = cyc + lo; e.max_cyc = cyc + hi;
    sb.push_back(e);
  endtask

  // Drive new pin levels on a falling edge and queue any edge they should produce.
  task automatic applyStimulus(input logic [W-1:0] pins, input logic [W-1:0] r,
                               input logic [W-1:0] f, input string tag);
    @(negedge clk);
    gpio_in = pins;
    if ((r | f) != '0) pushExpect(tag, r, f, 11, 14);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drained"}, 32'(sb.size() == 0), 32'd1);
  endtask

  task automatic clearAll(input string tag);
    @(negedge clk);
    event_clr = '1;
    @(negedge clk);
    event_clr = '0;
    checkOutput({tag, "_event"}, 32'(event_o), 32'd0);
    checkOutput({tag, "_irq"}, 32'(irq_o), 32'd0);
  endtask

  // Every pulse must match the oldest queued expectation, inside its window.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && (rise_o | fall_o) != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 32'(rise_o | fall_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.tag, "_rise"}, 32'(rise_o), 32'(mon_e.rise));
        checkOutput({mon_e.tag, "_fall"}, 32'(fall_o), 32'(mon_e.fall));
        checkOutput({mon_e.tag, "_window"},
                    32'(cyc >= mon_e.min_cyc && cyc <= mon_e.max_cyc), 32'd1);
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    gpio_in = '1;
    event_clr = '0;

    // Reset with every pin high, then expect one simultaneous rise.
    repeat (2) @(negedge clk);
    checkOutput("rst_level", 32'(level_o), 32'd0);
    checkOutput("rst_rise", 32'(rise_o), 32'd0);
    checkOutput("rst_fall", 32'(fall_o), 32'd0);
    checkOutput("rst_event", 32'(event_o), 32'd0);
    checkOutput("rst_irq", 32'(irq_o), 32'd0);
    rst_n = 1'b1;
    pushExpect("rst_rise_all", 24'hFFFFFF, '0, 11, 14);
    waitDrain("rst", 30);
    checkOutput("rst_level_after", 32'(level_o), 32'hFFFFFF);
    @(negedge clk);
    checkOutput("rst_irq_after", 32'(irq_o), 32'd1);
    checkOutput("rst_event_after", 32'(event_o), 32'hFFFFFF);

    applyStimulus('0, '0, 24'hFFFFFF, "all_fall");
    waitDrain("all_fall", 30);
    checkOutput("all_fall_level", 32'(level_o), 32'd0);
    clearAll("clr0");

    // Clean rising edge on pin 0.
    applyStimulus(24'h000001, 24'h000001, '0, "clean0");
    waitDrain("clean0", 30);
    checkOutput("clean0_level", 32'(level_o[0]), 32'd1);
    checkOutput("clean0_pulse", 32'(rise_o[0]), 32'd1);
    checkOutput("clean0_event_late", 32'(event_o[0]), 32'd0);
    @(negedge clk);
    checkOutput("clean0_event", 32'(event_o[0]), 32'd1);
    checkOutput("clean0_irq", 32'(irq_o), 32'd1);
    checkOutput("clean0_pulse_gone", 32'(rise_o[0]), 32'd0);

    // Six-cycle glitch on pin 5 must be ignored.
    applyStimulus(24'h000021, '0, '0, "glitch5");
    repeat (6) @(negedge clk);
    gpio_in = 24'h000001;
    repeat (20) @(negedge clk);
    checkOutput("glitch5_level", 32'(level_o[5]), 32'd0);
    checkOutput("glitch5_event", 32'(event_o[5]), 32'd0);

    // Bounce on pin 7: 1,0,1,0 every 3 cycles, then hold high.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      gpio_in[7] = ~k[0];
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    gpio_in[7] = 1'b1;
    pushExpect("bounce7", 24'h000080, '0, 7, 14);
    waitDrain("bounce7", 30);
    checkOutput("bounce7_level", 32'(level_o[7]), 32'd1);

    // Pins 0 and 7 drop together and must accept on the same tick.
    applyStimulus('0, '0, 24'h000081, "dual_fall");
    waitDrain("dual_fall", 30);
    clearAll("clr1");

    // Clear colliding with an accepted edge on pin 2.
    applyStimulus(24'h000004, 24'h000004, '0, "coll_rise2");
    waitDrain("coll_rise2", 30);
    @(negedge clk);
    checkOutput("coll_event_set", 32'(event_o[2]), 32'd1);
    applyStimulus('0, '0, 24'h000004, "coll_fall2");
    n = 0;
    while (fall_o[2] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("coll_fall_seen", 32'(fall_o[2]), 32'd1);
    event_clr[2] = 1'b1;
    @(negedge clk);
    checkOutput("coll_set_wins", 32'(event_o[2]), 32'd1);
    @(negedge clk);
    event_clr[2] = 1'b0;
    checkOutput("coll_clear", 32'(event_o[2]), 32'd0);
    checkOutput("coll_irq", 32'(irq_o), 32'd0);

    // Reset during qualification on pin 9 discards the partial count.
    applyStimulus(24'h000200, '0, '0, "midrst9");
    repeat (8) @(negedge clk);
    checkOutput("midrst9_pre_level", 32'(level_o[9]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pushExpect("midrst9_rise", 24'h000200, '0, 11, 14);
    waitDrain("midrst9", 30);
    checkOutput("midrst9_level", 32'(level_o), 32'h000200);
    repeat (5) @(negedge clk);
    checkOutput("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
